neureka_tcdm_serializer: RTL and testbench

Downstream stage of the accelerator's TCDM master port. It accepts one wide request (DW bits, word-aligned) per transaction and splits it into DW/NW sequential narrow-word accesses on a single memory port. Beats whose byte-enable slice is all zero are skipped. Read responses are reassembled into one wide response. It is used where the cluster interconnect offers fewer parallel banks than the accelerator's streamer bandwidth requires.

---
 rtl/neureka_tcdm_serializer.sv | 186 ++++++++++++++++++
 tb/tb_neureka_tcdm_serializer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_tcdm_serializer.sv
// ============================================================================
// neureka_tcdm_serializer
//   Splits one wide TCDM request into narrow-word beats on a single memory
//   port and reassembles read responses into one wide response.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module neureka_tcdm_serializer #(
  parameter int DW = 256,
  parameter int NW = 32,
  parameter int AW = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              wen_i,
  input  logic [AW-1:0]     add_i,
  input  logic [DW-1:0]     data_i,
  input  logic [DW/8-1:0]   be_i,
  output logic              r_valid_o,
  output logic [DW-1:0]     r_data_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_wen_o,
  output logic [AW-1:0]     mem_add_o,
  output logic [NW-1:0]     mem_data_o,
  output logic [NW/8-1:0]   mem_be_o,
  input  logic              mem_r_valid_i,
  input  logic [NW-1:0]     mem_r_data_i
);

  localparam int N  = DW / NW;
  localparam int NB = NW / 8;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                wen_q, wen_d;
  logic [AW-1:0]       add_q, add_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW/8-1:0]     be_q, be_d;
  logic [N-1:0]        mask_q, mask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       buf_q, buf_d;
  logic [1:0][IW-1:0]  fifo_q, fifo_d;
  logic                wptr_q, wptr_d;
  logic                rptr_q, rptr_d;

  logic [N-1:0]        act_mask;
  logic [N-1:0]        mask_clr;
  logic [IW-1:0]       beat;
  logic                push;
  logic                pop;

  always_comb begin
    act_mask = '0;
    for (int k = 0; k < N; k++) begin
      act_mask[k] = |be_i[k*NB +: NB];
    end
  end

  // Descending scan so the lowest pending beat wins.
  always_comb begin
    beat = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_q[k]) beat = IW'(k);
    end
  end

  assign mask_clr = mask_q & ~(N'(1) << beat);

  assign gnt_o      = (state_q == IDLE) & req_i & ~clear_i;
  assign mem_req_o  = (state_q == ISSUE);
  assign mem_wen_o  = mem_req_o & wen_q;
  assign mem_add_o  = mem_req_o ? add_q + (AW'(beat) << 2) : '0;
  assign mem_data_o = mem_req_o ? wdata_q[beat*NW +: NW] : '0;
  assign mem_be_o   = mem_req_o ? be_q[beat*NB +: NB] : '0;
  assign r_valid_o  = (state_q == RESP);
  assign r_data_o   = buf_q;

  // A response with no outstanding read belongs to an aborted transaction.
  assign push = (state_q == ISSUE) & mem_gnt_i & wen_q;
  assign pop  = mem_r_valid_i & (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    add_d   = add_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;

    if (pop) begin
      buf_d[fifo_q[rptr_q]*NW +: NW] = mem_r_data_i;
      rptr_d = ~rptr_q;
    end
    if (push) begin
      fifo_d[wptr_q] = beat;
      wptr_d = ~wptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (req_i) begin
          wen_d   = wen_i;
          add_d   = add_i & ~AW'(3);
          wdata_d = data_i;
          be_d    = be_i;
          mask_d  = act_mask;
          buf_d   = '0;
          state_d = (act_mask == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          mask_d = mask_clr;
          if (mask_clr == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d = IDLE;
      mask_d  = '0;
      cnt_d   = '0;
      buf_d   = '0;
      fifo_d  = '0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      add_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      fifo_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neureka_tcdm_serializer.sv
// ============================================================================
// tb_neureka_tcdm_serializer
//   Randomized bench with a beat-list reference model and a memory responder.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_neureka_tcdm_serializer;

  localparam int DW = 256;
  localparam int NW = 32;
  localparam int AW = 32;
  localparam int N  = DW / NW;
  localparam int NB = NW / 8;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } acc_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear_i = 1'b0;
  logic            req_i = 1'b0;
  logic            gnt_o;
  logic            wen_i = 1'b0;
  logic [AW-1:0]   add_i = '0;
  logic [DW-1:0]   data_i = '0;
  logic [DW/8-1:0] be_i = '0;
  logic            r_valid_o;
  logic [DW-1:0]   r_data_o;
  logic            mem_req_o;
  logic            mem_gnt_i = 1'b0;
  logic            mem_wen_o;
  logic [AW-1:0]   mem_add_o;
  logic [NW-1:0]   mem_data_o;
  logic [NW/8-1:0] mem_be_o;
  logic            mem_r_valid_i = 1'b0;
  logic [NW-1:0]   mem_r_data_i = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gnt_pct = 100;
  int stab_viol = 0;
  logic        seq_mode = 1'b0;
  logic [31:0] seq_base = '0;

  acc_t        obs[$];
  int          obs_cyc[$];
  int          rv_cyc[$];
  logic [DW-1:0] rv_dat[$];

  logic        pend = 1'b0;
  logic [31:0] pend_a = '0;
  logic        prev_stall = 1'b0;
  acc_t        prev_pay;

  neureka_tcdm_serializer #(.DW(DW), .NW(NW), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
    .req_i(req_i), .gnt_o(gnt_o), .wen_i(wen_i), .add_i(add_i),
    .data_i(data_i), .be_i(be_i), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_wen_o(mem_wen_o),
    .mem_add_o(mem_add_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_data_i(mem_r_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (seq_mode) return ((a - seq_base) >> 2) + 32'd1;
    return a ^ 32'h5A17_C3E9 ^ {a[15:0], a[31:16]};
  endfunction

  // Reference: each enabled beat k reads word (base + 4k); others stay zero.
  function automatic logic [DW-1:0] model_rdata(input logic w, input logic [31:0] a,
                                                 input logic [DW/8-1:0] b);
    logic [DW-1:0] r;
    logic [31:0]   base;
    r = '0;
    base = a & ~32'h3;
    if (w) begin
      for (int k = 0; k < N; k++)
        if (|b[k*NB +: NB]) r[k*NW +: NW] = rd_word(base + 32'(4 * k));
    end
    return r;
  endfunction

  // Memory responder and bus monitor.
  always @(negedge clk) begin
    acc_t cur;
    mem_r_valid_i = pend;
    mem_r_data_i  = pend ? rd_word(pend_a) : $urandom;
    mem_gnt_i     = ($urandom_range(99) < gnt_pct);
    cur = {mem_wen_o, mem_add_o, mem_data_o, mem_be_o};
    if (prev_stall && mem_req_o && cur !== prev_pay) stab_viol++;
    prev_stall = mem_req_o && !mem_gnt_i;
    prev_pay   = cur;
    pend   = mem_req_o && mem_gnt_i && mem_wen_o;
    pend_a = mem_add_o;
    if (mem_req_o && mem_gnt_i) begin
      obs.push_back(cur);
      obs_cyc.push_back(cyc);
    end
    if (r_valid_o) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(r_data_o);
    end
  end

  task automatic flush();
    obs.delete(); obs_cyc.delete(); rv_cyc.delete(); rv_dat.delete();
    stab_viol = 0;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] b, output int t);
    int n;
    n = 0;
    @(negedge clk); #1;
    wen_i = w; add_i = a; data_i = d; be_i = b; req_i = 1'b1;
    #1;
    while (!gnt_o && n < 50) begin @(negedge clk); #2; n++; end
    t = cyc;
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  task automatic wait_rv(input int budget);
    for (int i = 0; i < budget && rv_cyc.size() == 0; i++) begin
      @(negedge clk); #2;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*NW +: NW] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req_o, r_valid_o, mem_wen_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got req/rv/wen=%b required 000", {mem_req_o, r_valid_o, mem_wen_o});
    end
    checks++;
    if (r_data_o !== '0 || mem_add_o !== '0 || mem_data_o !== '0 || mem_be_o !== '0) begin
      errors++; $display("FAIL reset_data: got rdata=%h add=%h data=%h be=%h required all 0", r_data_o, mem_add_o, mem_data_o, mem_be_o);
    end
    req_i = 1'b1; #1;
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL reset_idle_gnt: got %b required 1", gnt_o); end
    req_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_read();
    int t;
    logic [DW-1:0] exp;
    flush(); seq_mode = 1'b1; seq_base = 32'h1000; gnt_pct = 100;
    for (int k = 0; k < N; k++) exp[k*NW +: NW] = 32'(k + 1);
    send(1'b1, 32'h1000, rand_data(), '1, t);
    wait_rv(40); settle(3);
    checks++;
    if (obs.size() != N) begin errors++; $display("FAIL full_read_beats: got %0d required %0d", obs.size(), N); end
    for (int k = 0; k < N && k < obs.size(); k++) begin
      checks++;
      if (obs[k].a !== 32'h1000 + 32'(4 * k) || obs_cyc[k] != t + 1 + k || obs[k].w !== 1'b1) begin
        errors++; $display("FAIL full_read_addr%0d: got %h@%0d required %h@%0d", k, obs[k].a, obs_cyc[k], 32'h1000 + 32'(4 * k), t + 1 + k);
      end
    end
    checks++;
    if (rv_cyc.size() != 1) begin errors++; $display("FAIL full_read_rvcount: got %0d required 1", rv_cyc.size()); end
    else begin
      checks++;
      if (rv_cyc[0] != t + 10) begin errors++; $display("FAIL full_read_lat: got %0d required 10", rv_cyc[0] - t); end
      checks++;
      if (rv_dat[0] !== exp) begin errors++; $display("FAIL full_read_data: got %h required %h", rv_dat[0], exp); end
    end
  endtask

  task automatic test_sparse_write();
    int t;
    logic [DW-1:0] d;
    logic [DW/8-1:0] b;
    logic [31:0] a;
    flush(); seq_mode = 1'b0; gnt_pct = 100;
    d = rand_data(); a = {$urandom_range(32'h0FFF_FFFF), 2'b00} | 32'h3;
    b = '0;
    b[2*NB +: NB] = 4'($urandom_range(14) + 1);
    b[5*NB +: NB] = 4'($urandom_range(14) + 1);
    send(1'b0, a, d, b, t);
    wait_rv(40); settle(3);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL sparse_beats: got %0d required 2", obs.size()); end
    else begin
      checks++;
      if (obs[0] !== acc_t'({1'b0, (a & ~32'h3) + 32'h8, d[2*NW +: NW], b[2*NB +: NB]})) begin
        errors++; $display("FAIL sparse_beat2: got %h", obs[0]);
      end
      checks++;
      if (obs[1] !== acc_t'({1'b0, (a & ~32'h3) + 32'h14, d[5*NW +: NW], b[5*NB +: NB]})) begin
        errors++; $display("FAIL sparse_beat5: got %h", obs[1]);
      end
    end
    checks++;
    if (rv_cyc.size() != 1 || rv_dat[0] !== '0 || rv_cyc[0] != t + 4) begin
      errors++; $display("FAIL sparse_resp: got count=%0d lat=%0d required count=1 lat=4 data=0",
                         rv_cyc.size(), (rv_cyc.size() > 0) ? rv_cyc[0] - t : -1);
    end
  endtask

  task automatic test_zero_be();
    int t;
    flush(); gnt_pct = 100;
    send(1'b1, $urandom, rand_data(), '0, t);
    wait_rv(10); settle(3);
    checks++;
    if (obs.size() != 0) begin errors++; $display("FAIL zero_be_beats: got %0d required 0", obs.size()); end
    checks++;
    if (rv_cyc.size() != 1 || rv_cyc[0] != t + 1 || rv_dat[0] !== '0) begin
      errors++; $display("FAIL zero_be_resp: got count=%0d lat=%0d required count=1 lat=1",
                         rv_cyc.size(), (rv_cyc.size() > 0) ? rv_cyc[0] - t : -1);
    end
  endtask

  task automatic test_random_stall();
    for (int it = 0; it < 6; it++) begin
      int t, idx;
      logic w, bad;
      logic [31:0] a;
      logic [DW-1:0] d;
      logic [DW/8-1:0] b;
      acc_t ea;
      flush(); seq_mode = 1'b0; gnt_pct = 50;
      w = (it % 2 == 0);
      a = $urandom; d = rand_data();
      for (int k = 0; k < N; k++) b[k*NB +: NB] = (it < 2 || $urandom_range(3) != 0) ? 4'($urandom_range(14) + 1) : 4'h0;
      send(w, a, d, b, t);
      wait_rv(200); settle(3);
      idx = 0; bad = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (|b[k*NB +: NB]) begin
          ea = {w, (a & ~32'h3) + 32'(4 * k), d[k*NW +: NW], b[k*NB +: NB]};
          if (idx >= obs.size() || obs[idx] !== ea) bad = 1'b1;
          idx++;
        end
      end
      checks++;
      if (bad || obs.size() != idx) begin
        errors++; $display("FAIL stall_beats%0d: got %0d beats required %0d (content match=%b)", it, obs.size(), idx, !bad);
      end
      checks++;
      if (stab_viol != 0) begin errors++; $display("FAIL stall_stable%0d: got %0d payload changes required 0", it, stab_viol); end
      checks++;
      if (rv_cyc.size() != 1) begin errors++; $display("FAIL stall_rvcount%0d: got %0d required 1", it, rv_cyc.size()); end
      else begin
        checks++;
        if (rv_dat[0] !== model_rdata(w, a, b)) begin
          errors++; $display("FAIL stall_data%0d: got %h required %h", it, rv_dat[0], model_rdata(w, a, b));
        end
        if (obs_cyc.size() > 0) begin
          checks++;
          if (rv_cyc[0] != obs_cyc[obs_cyc.size()-1] + 2) begin
            errors++; $display("FAIL stall_lat%0d: got %0d cycles after last grant required 2", it, rv_cyc[0] - obs_cyc[obs_cyc.size()-1]);
          end
        end
      end
    end
  endtask

  task automatic test_clear();
    int t, t2, n;
    logic [31:0] a;
    flush(); seq_mode = 1'b0; gnt_pct = 100;
    send(1'b1, $urandom, rand_data(), '1, t);
    n = 0;
    while (obs.size() < 3 && n < 50) begin @(negedge clk); #2; n++; end
    @(posedge clk); #1; clear_i = 1'b1;
    @(posedge clk); #1; clear_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0 || r_valid_o !== 1'b0) begin
      errors++; $display("FAIL clear_idle: got req=%b rv=%b required 0 0", mem_req_o, r_valid_o);
    end
    flush();
    a = $urandom;
    send(1'b1, a, rand_data(), '1, t2);
    wait_rv(40); settle(4);
    checks++;
    if (rv_cyc.size() != 1) begin errors++; $display("FAIL clear_rvcount: got %0d required 1", rv_cyc.size()); end
    else begin
      checks++;
      if (rv_dat[0] !== model_rdata(1'b1, a, '1) || rv_cyc[0] != t2 + 10) begin
        errors++; $display("FAIL clear_next_txn: got %h lat=%0d required %h lat=10", rv_dat[0], rv_cyc[0] - t2, model_rdata(1'b1, a, '1));
      end
    end
  endtask

  task automatic test_async_reset_wrap();
    int t, n;
    logic [DW/8-1:0] b;
    flush(); seq_mode = 1'b0; gnt_pct = 50;
    send(1'b0, $urandom, rand_data(), '1, t);
    n = 0;
    while (obs.size() < 2 && n < 100) begin @(negedge clk); #2; n++; end
    #1; rst_n = 1'b0; #1;
    checks++;
    if (mem_req_o !== 1'b0 || r_valid_o !== 1'b0 || mem_add_o !== '0 || mem_data_o !== '0) begin
      errors++; $display("FAIL async_reset: got req=%b rv=%b add=%h required all 0", mem_req_o, r_valid_o, mem_add_o);
    end
    @(negedge clk); #1; rst_n = 1'b1;
    flush(); settle(5);
    checks++;
    if (obs.size() != 0 || rv_cyc.size() != 0) begin
      errors++; $display("FAIL post_reset_quiet: got beats=%0d rv=%0d required 0 0", obs.size(), rv_cyc.size());
    end
    flush(); gnt_pct = 100;
    b = '0; b[0 +: 2*NB] = '1;
    send(1'b1, 32'hFFFF_FFFE, rand_data(), b, t);
    wait_rv(40); settle(3);
    checks++;
    if (obs.size() != 2 || obs[0].a !== 32'hFFFF_FFFC || obs[1].a !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_addr: got %0d beats first=%h required FFFFFFFC then 00000000",
                         obs.size(), (obs.size() > 0) ? obs[0].a : 32'hx);
    end
    checks++;
    if (rv_cyc.size() != 1 || rv_dat[0] !== model_rdata(1'b1, 32'hFFFF_FFFC, b) || rv_cyc[0] != t + 4) begin
      errors++; $display("FAIL wrap_resp: got count=%0d required 1 with lat=4 and model data", rv_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    settle(2);
    test_full_read();
    test_sparse_write();
    test_zero_be();
    test_random_stall();
    test_clear();
    test_async_reset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
